// File: rtl/serial_subtractor4_pkg.sv
// Shared definitions for the serial subtractor and the ALU control that drives it:
// FSM state encodings and the default operand width.
package serial_subtractor4_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } sub_state_t;

endpackage

// File: rtl/serial_subtractor4_full_subtractor1.sv
// One-bit full subtractor: computes a - b - bin and produces the borrow out.
module full_subtractor1 (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial a - b over WIDTH clock cycles, LSB first, with borrow, zero and
// two's-complement overflow flags registered on completion.
module serial_subtractor4
   import serial_subtractor4_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   sub_state_t       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [CW-1:0]    cnt;
   logic             borrow;
   logic             a_msb;
   logic             b_msb;
   logic             d_bit;
   logic             borrow_next;
   logic [WIDTH-1:0] diff_next;

   full_subtractor1 u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow),
      .diff (d_bit),
      .bout (borrow_next)
   );

   // Each new bit enters at the MSB, so after WIDTH shifts the LSB has reached bit 0.
   assign diff_next = {d_bit, res_sh[WIDTH-1:1]};
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         cnt    <= '0;
         borrow <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  a_msb  <= a[WIDTH-1];
                  b_msb  <= b[WIDTH-1];
                  res_sh <= '0;
                  borrow <= 1'b0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= diff_next;
               borrow <= borrow_next;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST_BIT) begin
                  diff  <= diff_next;
                  bout  <= borrow_next;
                  zero  <= (diff_next == '0);
                  ovf   <= (a_msb != b_msb) && (diff_next[WIDTH-1] != a_msb);
                  busy  <= 1'b0;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               // The pulse lands in the cycle after DONE, while the FSM is back in IDLE.
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
